ripple_carry_adder_4b: RTL and testbench

- 4-bit ripple-carry adder: A + B + Cin -> {Cout, Sum}.
- Arithmetic path is purely combinational, built as a chain of WIDTH full-adder cells with the carry rippling from bit 0 to bit WIDTH-1.
- A registered copy of the result is provided for downstream synchronous logic.
- Leaf arithmetic block used wherever a small unsigned add with carry-in/out is needed.

---
 rtl/ripple_carry_adder_4b.sv | 66 ++++++
 tb/tb_ripple_carry_adder_4b.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder_4b.sv
// Unsigned ripple-carry adder {Cout,Sum} = A+B+Cin, plus a registered copy of the result.
// Define RCA_OVERFLOW_EN to add the signed-overflow outputs ovf/ovf_q.
module ripple_carry_adder_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [WIDTH-1:0] Sum_q,
`ifdef RCA_OVERFLOW_EN
  output logic             ovf,
  output logic             ovf_q,
`endif
  output logic             Cout_q
);

  logic [WIDTH:0] c;

  assign c[0] = Cin;

  // One full-adder cell per bit; the carry ripples from bit 0 upwards.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p;
    assign p        = A[i] ^ B[i];
    assign Sum[i]   = p ^ c[i];
    assign c[i+1]   = (A[i] & B[i]) | (c[i] & p);
  end

  assign Cout = c[WIDTH];

`ifdef RCA_OVERFLOW_EN
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];
`endif

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign sum_d  = Sum;
  assign cout_d = Cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      Sum_q  <= '0;
      Cout_q <= 1'b0;
    end else begin
      Sum_q  <= sum_d;
      Cout_q <= cout_d;
    end
  end

`ifdef RCA_OVERFLOW_EN
  logic ovf_d;
  assign ovf_d = ovf;

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
`endif

endmodule

// File: tb/tb_ripple_carry_adder_4b.sv
// Self-checking bench for ripple_carry_adder_4b: exhaustive sweep, corners, register/reset timing, random.
module tb_ripple_carry_adder_4b;

  logic       clk;
  logic       rst;
  logic [3:0] A, B;
  logic       Cin;
  logic [3:0] Sum, Sum_q;
  logic       Cout, Cout_q;
`ifdef RCA_OVERFLOW_EN
  logic       ovf, ovf_q;
`endif

  int tests;
  int fails;

  ripple_carry_adder_4b #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .Sum    (Sum),
    .Cout   (Cout),
    .Sum_q  (Sum_q),
`ifdef RCA_OVERFLOW_EN
    .ovf    (ovf),
    .ovf_q  (ovf_q),
`endif
    .Cout_q (Cout_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition.
  function automatic logic [4:0] ref_add(input int a, input int b, input int ci);
    int r;
    r = a + b + ci;
    return r[4:0];
  endfunction

`ifdef RCA_OVERFLOW_EN
  function automatic logic ref_ovf(input int a, input int b, input int ci);
    int sa, sb, r;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    r  = sa + sb + ci;
    return (r > 7) || (r < -8);
  endfunction
`endif

  initial begin
    logic [4:0] held;
    int ra, rb, rc;
    bit rr;
    tests = 0;
    fails = 0;
    rst = 1'b1; A = '0; B = '0; Cin = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("reset_sum_q", {1'b0, Sum_q}, 5'd0);
    chk("reset_cout_q", {4'd0, Cout_q}, 5'd0);
    rst = 1'b0;

    // Exhaustive combinational sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++) begin
          A = 4'(a); B = 4'(b); Cin = 1'(ci);
          #10;
          chk($sformatf("sweep_%0d+%0d+%0d", a, b, ci), {Cout, Sum}, ref_add(a, b, ci));
        end

    // Corner values against literal expectations
    A = 4'd0;  B = 4'd0;  Cin = 1'b0; #1; chk("corner_0+0+0",    {Cout, Sum}, 5'b0_0000);
    A = 4'd15; B = 4'd15; Cin = 1'b1; #1; chk("corner_15+15+1",  {Cout, Sum}, 5'b1_1111);
    A = 4'd15; B = 4'd0;  Cin = 1'b1; #1; chk("corner_ripple",   {Cout, Sum}, 5'b1_0000);
    A = 4'd15; B = 4'd15; Cin = 1'b0; #1; chk("corner_15+15+0",  {Cout, Sum}, 5'b1_1110);
    A = 4'd15; B = 4'd1;  Cin = 1'b0; #1; chk("corner_wrap",     {Cout, Sum}, 5'b1_0000);
    A = 4'd9;  B = 4'd6;  Cin = 1'b1; #1; chk("corner_9+6+1",    {Cout, Sum}, 5'b1_0000);
    A = 4'd5;  B = 4'd3;  Cin = 1'b0; #1; chk("corner_5+3+0",    {Cout, Sum}, 5'b0_1000);

    // Register latency
    @(negedge clk); rst = 1'b0; A = 4'd3; B = 4'd4; Cin = 1'b1;
    @(posedge clk); #1;
    chk("lat_first_edge", {Cout_q, Sum_q}, 5'b0_1000);
    A = 4'd12; B = 4'd10; Cin = 1'b0; #2;
    chk("lat_hold_between_edges", {Cout_q, Sum_q}, 5'b0_1000);

    // Synchronous reset with comb path unaffected
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("srst_regs_clear", {Cout_q, Sum_q}, 5'b0_0000);
    chk("srst_comb_valid", {Cout, Sum}, 5'b1_0110);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("srst_release", {Cout_q, Sum_q}, 5'b1_0110);

    // Reset is not asynchronous
    @(negedge clk); rst = 1'b1; #1;
    chk("srst_not_async", {Cout_q, Sum_q}, 5'b1_0110);
    @(posedge clk); #1;
    chk("srst_next_edge", {Cout_q, Sum_q}, 5'b0_0000);
    @(negedge clk); rst = 1'b0;

`ifdef RCA_OVERFLOW_EN
    A = 4'd7; B = 4'd1; Cin = 1'b0; #1;
    chk("ovf_7+1", {4'd0, ovf}, 5'd1);
    A = 4'd8; B = 4'd8; Cin = 1'b0; #1;
    chk("ovf_8+8", {4'd0, ovf}, 5'd1);
    chk("ovf_8+8_cout", {4'd0, Cout}, 5'd1);
    @(posedge clk); #1;
    chk("ovf_q_follow", {4'd0, ovf_q}, 5'd1);
    @(negedge clk); A = 4'd3; B = 4'd2; Cin = 1'b0; #1;
    chk("ovf_3+2", {4'd0, ovf}, 5'd0);
    @(negedge clk); A = 4'd7; B = 4'd1; rst = 1'b1;
    @(posedge clk); #1;
    chk("ovf_q_reset", {4'd0, ovf_q}, 5'd0);
    @(negedge clk); rst = 1'b0;
`endif

    // Randomized: comb result and registered result one edge later
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ra = int'($urandom_range(15));
      rb = int'($urandom_range(15));
      rc = int'($urandom_range(1));
      rr = ($urandom_range(7) == 0);
      A = 4'(ra); B = 4'(rb); Cin = 1'(rc); rst = rr;
      #1;
      chk($sformatf("rnd_comb_%0d", n), {Cout, Sum}, ref_add(ra, rb, rc));
`ifdef RCA_OVERFLOW_EN
      chk($sformatf("rnd_ovf_%0d", n), {4'd0, ovf}, {4'd0, ref_ovf(ra, rb, rc)});
`endif
      held = rr ? 5'd0 : ref_add(ra, rb, rc);
      @(posedge clk); #1;
      chk($sformatf("rnd_reg_%0d", n), {Cout_q, Sum_q}, held);
`ifdef RCA_OVERFLOW_EN
      chk($sformatf("rnd_ovfq_%0d", n), {4'd0, ovf_q},
          {4'd0, rr ? 1'b0 : ref_ovf(ra, rb, rc)});
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
